// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit with HI/LO result registers.
// MULT uses radix-2 Booth, DIV uses restoring division on magnitudes; both take 33 cycles.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [32:0] booth_sum_s;
  logic [32:0] shifted_s;
  logic        fits_s;
  logic [31:0] diff_s;

  // Unsigned magnitude of a two's complement word; -2^31 maps to 32'h8000_0000.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    if (x[31]) begin
      mag32 = 32'd0 - x;
    end else begin
      mag32 = x;
    end
  endfunction

  // Booth add/subtract on the sign-extended upper half, and the restoring trial subtract.
  always_comb begin
    case (acc_q[1:0])
      2'b01:   booth_sum_s = {acc_q[64], acc_q[64:33]} + {mcand_q[31], mcand_q};
      2'b10:   booth_sum_s = {acc_q[64], acc_q[64:33]} - {mcand_q[31], mcand_q};
      default: booth_sum_s = {acc_q[64], acc_q[64:33]};
    endcase
    shifted_s = {rem_q, quo_q[31]};
    fits_s    = (shifted_s >= {1'b0, dvs_q});
    diff_s    = shifted_s[31:0] - dvs_q;
  end

  // Next-state and next-output computation for the IDLE/RUN/FIX sequencer.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = 6'd0;
          dz_d   = 1'b0;
          busy_d = 1'b1;
          if (op) begin
            rem_d     = 32'd0;
            quo_d     = mag32(a);
            dvs_d     = mag32(b);
            quo_neg_d = a[31] ^ b[31];
            rem_neg_d = a[31];
            if (b == 32'd0) begin
              dz_d    = 1'b1;
              state_d = ST_FIX;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            acc_d   = {32'd0, b, 1'b0};
            mcand_d = a;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (op_q) begin
          if (fits_s) begin
            rem_d = diff_s;
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted_s[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {booth_sum_s, acc_q[32:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        // A divide-by-zero abort leaves HI/LO untouched.
        if (dz_q) begin
          hi_d = hi_q;
          lo_d = lo_q;
        end else if (op_q) begin
          lo_d = quo_neg_q ? (32'd0 - quo_q) : quo_q;
          hi_d = rem_neg_q ? (32'd0 - rem_q) : rem_q;
        end else begin
          {hi_d, lo_d} = acc_q[64:1];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 1'b0;
      cnt_q     <= 6'd0;
      acc_q     <= 65'd0;
      mcand_q   <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op_i = 1'b0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // Returns {remainder, quotient}; 64-bit arithmetic makes -2^31/-1 wrap naturally.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    longint q, r;
    logic [63:0] qv, rv;
    q = longint'($signed(x)) / longint'($signed(y));
    r = longint'($signed(x)) % longint'($signed(y));
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Issues one operation, scrambles operands after acceptance, waits (bounded) for done.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output bit busy_ok, output bit stable);
    logic [31:0] h0, l0;
    bit seen;
    h0 = hi; l0 = lo;
    start = 1'b1; op_i = o; a_i = x; b_i = y;
    @(posedge clk); #1;
    start = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 1'($urandom);
    busy_ok = busy; stable = 1'b1; lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        seen = 1'b1;
      end else begin
        busy_ok = busy_ok & busy;
        if (hi !== h0 || lo !== l0) stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; op_i = 1'b0; a_i = 32'd3; b_i = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else pass_cnt++;
    total_cnt++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, div_zero}); else pass_cnt++;
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_no_start busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_mult;
    logic [31:0] x, y;
    logic [63:0] exp;
    int lat; bit bok, stb;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin x = 32'hFFFF_FFFD; y = 32'd7; end
        1: begin x = 32'h8000_0000; y = 32'h8000_0000; end
        2: begin x = 32'h7FFF_FFFF; y = 32'h8000_0000; end
        3: begin x = 32'd0; y = 32'hFFFF_FFFF; end
        default: begin x = $urandom; y = $urandom; end
      endcase
      exp = ref_mult(x, y);
      run_op(1'b0, x, y, lat, bok, stb);
      total_cnt++; if (lat !== 33) $display("FAIL mult%0d_latency got %0d want 33", i, lat); else pass_cnt++;
      total_cnt++; if (!bok || !stb || busy !== 1'b0) $display("FAIL mult%0d_busy_stable got busy_ok=%0d stable=%0d busy=%b want 1 1 0", i, bok, stb, busy); else pass_cnt++;
      total_cnt++; if ({hi, lo} !== exp) $display("FAIL mult%0d_result got %h want %h", i, {hi, lo}, exp); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL mult%0d_done_pulse got %b want 0", i, done); else pass_cnt++;
    end
  endtask

  task automatic test_div;
    logic [31:0] x, y;
    logic [63:0] exp;
    int lat; bit bok, stb;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin x = 32'hFFFF_FFF9; y = 32'd2; end
        1: begin x = 32'd7; y = 32'hFFFF_FFFE; end
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: begin x = 32'h8000_0000; y = 32'h8000_0000; end
        4: begin x = 32'd5; y = 32'h8000_0000; end
        default: begin
          x = $urandom;
          y = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
          if (i % 3 == 0) y = 32'd0 - y;
          if (y == 32'd0) y = 32'd1;
        end
      endcase
      exp = ref_div(x, y);
      run_op(1'b1, x, y, lat, bok, stb);
      total_cnt++; if (lat !== 33) $display("FAIL div%0d_latency got %0d want 33", i, lat); else pass_cnt++;
      total_cnt++; if (!bok || !stb || busy !== 1'b0 || div_zero !== 1'b0) $display("FAIL div%0d_flags got busy_ok=%0d stable=%0d busy=%b dz=%b want 1 1 0 0", i, bok, stb, busy, div_zero); else pass_cnt++;
      total_cnt++; if ({hi, lo} !== exp) $display("FAIL div%0d_result got %h want %h", i, {hi, lo}, exp); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero;
    int lat; bit bok, stb;
    run_op(1'b0, 32'd5, 32'd6, lat, bok, stb);
    @(posedge clk); #1;
    total_cnt++; if ({hi, lo} !== 64'd30) $display("FAIL dz_preload got %h want 30", {hi, lo}); else pass_cnt++;
    run_op(1'b1, 32'd9, 32'd0, lat, bok, stb);
    total_cnt++; if (lat !== 1 || !bok || busy !== 1'b0) $display("FAIL dz_timing got lat=%0d busy_ok=%0d busy=%b want 1 1 0", lat, bok, busy); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", div_zero); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'd30) $display("FAIL dz_hold got %h want 30", {hi, lo}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (div_zero !== 1'b1 || done !== 1'b0) $display("FAIL dz_sticky got dz=%b done=%b want 1 0", div_zero, done); else pass_cnt++;
    run_op(1'b0, 32'd3, 32'd3, lat, bok, stb);
    total_cnt++; if (div_zero !== 1'b0 || lo !== 32'd9) $display("FAIL dz_clear got dz=%b lo=%h want 0 9", div_zero, lo); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy;
    int dones; logic [31:0] lo_at, hi_at;
    start = 1'b1; op_i = 1'b0; a_i = 32'd4; b_i = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op_i = 1'b1; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; lo_at = 32'hDEAD_BEEF; hi_at = 32'hDEAD_BEEF;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin dones++; lo_at = lo; hi_at = hi; end
    end
    total_cnt++; if (dones !== 1) $display("FAIL swb_done_count got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if ({hi_at, lo_at} !== 64'd20) $display("FAIL swb_result got %h want 20", {hi_at, lo_at}); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL swb_idle got busy=%b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op;
    int dones;
    start = 1'b1; op_i = 1'b1; a_i = 32'd1000; b_i = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    total_cnt++; if ({hi, lo} !== 64'd0 || {busy, done, div_zero} !== 3'b000) $display("FAIL midreset_clear got %h %b want 0 000", {hi, lo}, {busy, done, div_zero}); else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL midreset_no_done got %0d active cycles want 0", dones); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat; bit seen;
    start = 1'b1; op_i = 1'b0; a_i = 32'd2; b_i = 32'd3;
    @(posedge clk); #1;
    a_i = 32'd11; b_i = 32'd13;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    total_cnt++; if (lat !== 33 || lo !== 32'd6) $display("FAIL b2b_first got lat=%0d lo=%h want 33 6", lat, lo); else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); else pass_cnt++;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    total_cnt++; if (lat !== 33 || {hi, lo} !== 64'd143) $display("FAIL b2b_second got lat=%0d res=%h want 33 143", lat, {hi, lo}); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_start_while_busy;
    test_reset_mid_op;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
